// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types, also used by the ALU and control unit.
package reg_file_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: NREGS:1 mux over the storage array.
// Build option REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module reg_read_port
    import reg_file_pkg::*;
(
    input  word_t    regs [NREGS],
    input  reg_idx_t addr,
`ifdef REGFILE_BYPASS_EN
    input  logic     wr_en,
    input  reg_idx_t wr_addr,
    input  word_t    wr_data,
`endif
    output word_t    data
);

    always_comb begin
        data = regs[addr];
`ifdef REGFILE_BYPASS_EN
        // Forward the pending write so the reader sees the new value before the edge.
        if (wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// 8 x 8-bit register file: two async read ports, one sync write port, sync reset.
// Build option REGFILE_BYPASS_EN enables write-to-read forwarding on both ports.
module reg_file
    import reg_file_pkg::*;
(
    input  logic     CLK,
    input  logic     RESET,
    input  word_t    IN,
    input  reg_idx_t INADDRESS,
    input  logic     WRITE,
    input  reg_idx_t OUT1ADDRESS,
    input  reg_idx_t OUT2ADDRESS,
    output word_t    OUT1,
    output word_t    OUT2
);

    word_t regs [NREGS];

    // Reset takes priority, so a write coincident with reset is dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WRITE) begin
            regs[INADDRESS] <= IN;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    assign wr_live = WRITE && !RESET;
`endif

    reg_read_port u_port1 (
        .regs    (regs),
        .addr    (OUT1ADDRESS),
`ifdef REGFILE_BYPASS_EN
        .wr_en   (wr_live),
        .wr_addr (INADDRESS),
        .wr_data (IN),
`endif
        .data    (OUT1)
    );

    reg_read_port u_port2 (
        .regs    (regs),
        .addr    (OUT2ADDRESS),
`ifdef REGFILE_BYPASS_EN
        .wr_en   (wr_live),
        .wr_addr (INADDRESS),
        .wr_data (IN),
`endif
        .data    (OUT2)
    );

endmodule
